// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB write-back inputs, the two decode
// read ports, the forwarded write-back value and the retire counter.
interface wb_regfile_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                  RegWrite3;
    logic                  MemotoReg3;
    logic [DATA_WIDTH-1:0] DataOut3;
    logic [DATA_WIDTH-1:0] Result3;
    logic [ADDR_WIDTH-1:0] RegWriteIndex3;
    logic [ADDR_WIDTH-1:0] ReadIndexA;
    logic [ADDR_WIDTH-1:0] ReadIndexB;
    logic [DATA_WIDTH-1:0] ReadDataA;
    logic [DATA_WIDTH-1:0] ReadDataB;
    logic [DATA_WIDTH-1:0] WbData;
    logic [CNT_WIDTH-1:0]  RetireCount;

    // Pipeline / decode side: drives write-back and read indices.
    modport master (
        output RegWrite3, MemotoReg3, DataOut3, Result3, RegWriteIndex3,
        output ReadIndexA, ReadIndexB,
        input  ReadDataA, ReadDataB, WbData, RetireCount
    );

    // Register file side.
    modport slave (
        input  RegWrite3, MemotoReg3, DataOut3, Result3, RegWriteIndex3,
        input  ReadIndexA, ReadIndexB,
        output ReadDataA, ReadDataB, WbData, RetireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage sink and general register file.
// Selects load data vs ALU result, commits it on the clock edge, serves two
// combinational read ports and counts committed writes (wrapping).
// Optional macro WB_REGFILE_BYPASS_EN: a read of the register being written
// this cycle returns the write-back value instead of the stored one.
module wb_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16,
    parameter int CNT_WIDTH  = 16
) (
    input logic          i_clk,
    input logic          i_rst,
    wb_regfile_if.slave  bus
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] NUM_REGS_L = (ADDR_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [CNT_WIDTH-1:0]  r_retire;

    logic [DATA_WIDTH-1:0] w_wb;
    logic                  w_wr_valid;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_rd_a_ok;
    logic                  w_rd_b_ok;
    logic [IDX_W-1:0]      w_rd_a_idx;
    logic [IDX_W-1:0]      w_rd_b_idx;

    // Out-of-range indices (only possible when NUM_REGS < 2**ADDR_WIDTH) never touch storage.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
        return {1'b0, idx} < NUM_REGS_L;
    endfunction

    assign w_wb       = bus.MemotoReg3 ? bus.DataOut3 : bus.Result3;
    assign w_wr_valid = bus.RegWrite3 && in_range(bus.RegWriteIndex3);
    assign w_wr_idx   = bus.RegWriteIndex3[IDX_W-1:0];
    assign w_rd_a_ok  = in_range(bus.ReadIndexA);
    assign w_rd_b_ok  = in_range(bus.ReadIndexB);
    assign w_rd_a_idx = bus.ReadIndexA[IDX_W-1:0];
    assign w_rd_b_idx = bus.ReadIndexB[IDX_W-1:0];

    assign bus.WbData      = w_wb;
    assign bus.RetireCount = r_retire;

    // Commit the selected write-back value and count retired writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_retire <= '0;
        end else if (w_wr_valid) begin
            r_regs[w_wr_idx] <= w_wb;
            r_retire         <= r_retire + CNT_WIDTH'(1);
        end
    end

    // Read port A: stored value, or the in-flight write when bypass is built in.
    always_comb begin
        bus.ReadDataA = '0;
        if (w_rd_a_ok) begin
            bus.ReadDataA = r_regs[w_rd_a_idx];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (!i_rst && w_wr_valid && (bus.ReadIndexA == bus.RegWriteIndex3)) begin
            bus.ReadDataA = w_wb;
        end
`else
`endif
    end

    // Read port B: resolved independently of port A.
    always_comb begin
        bus.ReadDataB = '0;
        if (w_rd_b_ok) begin
            bus.ReadDataB = r_regs[w_rd_b_idx];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (!i_rst && w_wr_valid && (bus.ReadIndexB == bus.RegWriteIndex3)) begin
            bus.ReadDataB = w_wb;
        end
`else
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a full-size instance (16 regs, 16-bit count)
// and a reduced instance (8 regs, 4-bit count) for wrap and out-of-range cases.
module tb_wb_regfile;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CNT_WIDTH(16)) if0 ();
    wb_regfile_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CNT_WIDTH(4))  if1 ();

    wb_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_REGS(16), .CNT_WIDTH(16)) dut0 (
        .i_clk (clk),
        .i_rst (rst0),
        .bus   (if0)
    );

    wb_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_REGS(8), .CNT_WIDTH(4)) dut1 (
        .i_clk (clk),
        .i_rst (rst1),
        .bus   (if1)
    );

    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic expect_val(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if0.RegWrite3 = 0; if0.MemotoReg3 = 0; if0.DataOut3 = '0; if0.Result3 = '0;
        if0.RegWriteIndex3 = '0; if0.ReadIndexA = '0; if0.ReadIndexB = '0;
        if1.RegWrite3 = 0; if1.MemotoReg3 = 0; if1.DataOut3 = '0; if1.Result3 = '0;
        if1.RegWriteIndex3 = '0; if1.ReadIndexA = '0; if1.ReadIndexB = '0;

        edge_step();
        edge_step();
        rst0 = 0;
        rst1 = 0;
        #1;

        // 1: after reset every index reads 0 on both ports
        for (int i = 0; i < 16; i++) begin
            if0.ReadIndexA = 4'(i);
            if0.ReadIndexB = 4'(15 - i);
            #1;
            expect_val(16'h0); chk($sformatf("rst_rdA[%0d]", i), if0.ReadDataA);
            expect_val(16'h0); chk($sformatf("rst_rdB[%0d]", 15 - i), if0.ReadDataB);
        end
        expect_val(16'h0); chk("rst_count", if0.RetireCount);

        // 2: ALU result then load data into reg 3
        if0.RegWrite3 = 1; if0.MemotoReg3 = 0; if0.Result3 = 16'h1234;
        if0.DataOut3 = 16'h5555; if0.RegWriteIndex3 = 4'd3; if0.ReadIndexA = 4'd3;
        #1;
        expect_val(16'h1234); chk("wb_sel_alu", if0.WbData);
        edge_step();
        if0.RegWrite3 = 0;
        #1;
        expect_val(16'h1234); chk("wr_alu_rdA", if0.ReadDataA);
        expect_val(16'd1);    chk("wr_alu_count", if0.RetireCount);
        if0.RegWrite3 = 1; if0.MemotoReg3 = 1; if0.DataOut3 = 16'hBEEF;
        #1;
        expect_val(16'hBEEF); chk("wb_sel_mem", if0.WbData);
        edge_step();
        if0.RegWrite3 = 0;
        #1;
        expect_val(16'hBEEF); chk("wr_mem_rdA", if0.ReadDataA);
        expect_val(16'd2);    chk("wr_mem_count", if0.RetireCount);

        // 3: same-cycle write/read of reg 5 (holding 0001)
        if0.RegWrite3 = 1; if0.MemotoReg3 = 0; if0.Result3 = 16'h0001; if0.RegWriteIndex3 = 4'd5;
        edge_step();
        if0.Result3 = 16'hA5A5;
        if0.ReadIndexA = 4'd5; if0.ReadIndexB = 4'd5;
        #1;
        expect_val(BYPASS ? 16'hA5A5 : 16'h0001); chk("same_cyc_rdA", if0.ReadDataA);
        expect_val(BYPASS ? 16'hA5A5 : 16'h0001); chk("same_cyc_rdB", if0.ReadDataB);
        edge_step();
        if0.RegWrite3 = 0;
        #1;
        expect_val(16'hA5A5); chk("after_edge_rdA", if0.ReadDataA);
        expect_val(16'hA5A5); chk("after_edge_rdB", if0.ReadDataB);
        expect_val(16'd4);    chk("same_cyc_count", if0.RetireCount);

        // 4: RegWrite3 low for 4 cycles -> nothing commits
        if0.RegWrite3 = 0; if0.MemotoReg3 = 0; if0.Result3 = 16'hFFFF;
        if0.RegWriteIndex3 = 4'd7; if0.ReadIndexA = 4'd7;
        for (int c = 0; c < 4; c++) begin
            edge_step();
            expect_val(16'h0);    chk($sformatf("nowr_reg7[%0d]", c), if0.ReadDataA);
            expect_val(16'd4);    chk($sformatf("nowr_count[%0d]", c), if0.RetireCount);
            expect_val(16'hFFFF); chk($sformatf("nowr_wb[%0d]", c), if0.WbData);
        end

        // 5: write regs 1..4, then async reset mid-cycle
        if0.RegWrite3 = 1;
        for (int i = 1; i <= 4; i++) begin
            if0.RegWriteIndex3 = 4'(i);
            if0.Result3 = 16'(16'h1111 * i);
            edge_step();
        end
        if0.RegWrite3 = 0; if0.ReadIndexA = 4'd2;
        #1;
        expect_val(16'h2222); chk("pre_rst_reg2", if0.ReadDataA);
        expect_val(16'd8);    chk("pre_rst_count", if0.RetireCount);
        rst0 = 1;
        if0.RegWrite3 = 1; if0.RegWriteIndex3 = 4'd6; if0.Result3 = 16'h7777;
        #1;
        expect_val(16'h0); chk("async_rst_count", if0.RetireCount);
        for (int i = 1; i <= 4; i++) begin
            if0.ReadIndexA = 4'(i);
            #1;
            expect_val(16'h0); chk($sformatf("async_rst_reg[%0d]", i), if0.ReadDataA);
        end
        if0.ReadIndexA = 4'd6;
        edge_step();
        expect_val(16'h0);    chk("rst_held_rd6", if0.ReadDataA);
        expect_val(16'h0);    chk("rst_held_count", if0.RetireCount);
        expect_val(16'h7777); chk("rst_held_wb", if0.WbData);
        rst0 = 0;
        if0.RegWrite3 = 0;
        #1;
        expect_val(16'h0); chk("rst_write_ignored", if0.ReadDataA);
        if0.RegWrite3 = 1;
        edge_step();
        if0.RegWrite3 = 0;
        #1;
        expect_val(16'h7777); chk("resume_rd6", if0.ReadDataA);
        expect_val(16'd1);    chk("resume_count", if0.RetireCount);

        // 6: 4-bit counter wraps after 16 writes; 8-register file drops idx 9
        if1.RegWrite3 = 1; if1.MemotoReg3 = 0;
        for (int i = 0; i < 15; i++) begin
            if1.RegWriteIndex3 = 4'(i % 8);
            if1.Result3 = 16'(i);
            edge_step();
        end
        if1.RegWrite3 = 0;
        #1;
        expect_val(16'hF); chk("cnt_all_ones", {12'h0, if1.RetireCount});
        if1.RegWrite3 = 1; if1.RegWriteIndex3 = 4'd0; if1.Result3 = 16'h00AA;
        edge_step();
        if1.RegWrite3 = 0;
        #1;
        expect_val(16'h0); chk("cnt_wrap", {12'h0, if1.RetireCount});
        if1.ReadIndexA = 4'd0;
        #1;
        expect_val(16'h00AA); chk("wrap_write_reg0", if1.ReadDataA);
        if1.RegWrite3 = 1; if1.RegWriteIndex3 = 4'd9; if1.Result3 = 16'h9999;
        if1.ReadIndexA = 4'd9; if1.ReadIndexB = 4'd1;
        #1;
        expect_val(16'h0); chk("oor_same_cyc_rd9", if1.ReadDataA);
        edge_step();
        if1.RegWrite3 = 0;
        #1;
        expect_val(16'h0);    chk("oor_rd9", if1.ReadDataA);
        expect_val(16'h0009); chk("oor_no_alias_reg1", if1.ReadDataB);
        expect_val(16'h0);    chk("oor_count", {12'h0, if1.RetireCount});
        if1.ReadIndexA = 4'd7; if1.ReadIndexB = 4'd15;
        #1;
        expect_val(16'h0007); chk("small_reg7", if1.ReadDataA);
        expect_val(16'h0);    chk("small_rd15", if1.ReadDataB);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
